// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus between if_stage and instruction memory.
//   imem_req   : fetch request, driven by the fetch stage
//   imem_addr  : fetch address, driven by the fetch stage
//   imem_ack   : read data valid this cycle, driven by memory
//   imem_rdata : instruction word, valid when imem_ack=1
interface if_stage_if #(
   parameter int unsigned ADDR_W = 32
) ();
   localparam int unsigned DATA_W = 32;

   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [DATA_W-1:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack bus, holds the
// IF/ID register and feeds the opcode field to the control decoder.
// Handles memory wait states, hazard stalls (with a one-entry skid buffer)
// and branch/jump redirects.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   imem            : instruction-memory bus (master side)
//   stall           : hazard stall, holds IF/ID and PC
//   redirect_valid  : flush and reload PC from redirect_pc
//   ifid_valid/instr/pc4 : IF/ID pipeline register
//   opcode          : ifid_instr[31:26] when valid, else 0 (NOP)
// Optional: define IF_PERF_CNT_EN to add perf_fetch_cnt / perf_bubble_cnt.
module if_stage #(
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   if_stage_if.master        imem,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              ifid_valid,
   output logic [31:0]       ifid_instr,
   output logic [ADDR_W-1:0] ifid_pc4,
   output logic [5:0]        opcode
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0]       perf_fetch_cnt,
   output logic [31:0]       perf_bubble_cnt
`endif
);

   localparam int unsigned INSTR_W = 32;
   localparam int unsigned OP_W    = 6;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_e;

   state_e               state_q, state_d;
   logic [ADDR_W-1:0]    pc_q, pc_d;
   logic                 req_q, req_d;
   logic                 valid_q, valid_d;
   logic [INSTR_W-1:0]   instr_q, instr_d;
   logic [ADDR_W-1:0]    pc4_q, pc4_d;
   logic [OP_W-1:0]      opcode_q, opcode_d;
   logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;
   logic [ADDR_W-1:0]    skid_pc4_q, skid_pc4_d;
   logic [ADDR_W-1:0]    pc_inc;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         req_q        <= 1'b0;
         valid_q      <= 1'b0;
         instr_q      <= '0;
         pc4_q        <= '0;
         opcode_q     <= '0;
         skid_instr_q <= '0;
         skid_pc4_q   <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_q        <= req_d;
         valid_q      <= valid_d;
         instr_q      <= instr_d;
         pc4_q        <= pc4_d;
         opcode_q     <= opcode_d;
         skid_instr_q <= skid_instr_d;
         skid_pc4_q   <= skid_pc4_d;
      end
   end

   // Next-state and IF/ID update
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      valid_d      = valid_q;
      instr_d      = instr_q;
      pc4_d        = pc4_q;
      skid_instr_d = skid_instr_q;
      skid_pc4_d   = skid_pc4_q;
      pc_inc       = pc_q + ADDR_W'(4);

      case (state_q)
         IDLE: state_d = FETCH;
         FETCH: begin
            if (imem.imem_ack) begin
               pc_d = pc_inc;
               if (stall) begin
                  // Accepted word parks in the skid buffer until the stall drops
                  skid_instr_d = imem.imem_rdata;
                  skid_pc4_d   = pc_inc;
                  state_d      = HOLD;
               end else begin
                  valid_d = 1'b1;
                  instr_d = imem.imem_rdata;
                  pc4_d   = pc_inc;
               end
            end else if (!stall) begin
               valid_d = 1'b0;
            end
         end
         HOLD: begin
            // No request is outstanding here, so any ack is ignored
            if (!stall) begin
               valid_d      = 1'b1;
               instr_d      = skid_instr_q;
               pc4_d        = skid_pc4_q;
               skid_instr_d = '0;
               skid_pc4_d   = '0;
               state_d      = FETCH;
            end
         end
         default: state_d = IDLE;
      endcase

      // Redirect beats stall and discards a same-cycle ack; IF/ID data is left stale
      if (redirect_valid) begin
         pc_d         = {redirect_pc[ADDR_W-1:2], 2'b00};
         valid_d      = 1'b0;
         instr_d      = instr_q;
         pc4_d        = pc4_q;
         skid_instr_d = '0;
         skid_pc4_d   = '0;
         state_d      = FETCH;
      end

      req_d    = (state_d == FETCH);
      opcode_d = valid_d ? instr_d[INSTR_W-1 -: OP_W] : '0;
   end

   assign imem.imem_req  = req_q;
   assign imem.imem_addr = pc_q;
   assign ifid_valid     = valid_q;
   assign ifid_instr     = instr_q;
   assign ifid_pc4       = pc4_q;
   assign opcode         = opcode_q;

`ifdef IF_PERF_CNT_EN
   logic        fetch_inc_c;
   logic        bubble_inc_c;
   logic [31:0] perf_fetch_q, perf_fetch_d;
   logic [31:0] perf_bubble_q, perf_bubble_d;

   // Count IF/ID valid loads and bubble/flush writes
   always_comb begin
      fetch_inc_c  = 1'b0;
      bubble_inc_c = 1'b0;
      if (redirect_valid) begin
         bubble_inc_c = 1'b1;
      end else if (state_q == FETCH) begin
         fetch_inc_c  = imem.imem_ack & ~stall;
         bubble_inc_c = ~imem.imem_ack & ~stall;
      end else if (state_q == HOLD) begin
         fetch_inc_c  = ~stall;
      end
      perf_fetch_d  = perf_fetch_q + 32'(fetch_inc_c);
      perf_bubble_d = perf_bubble_q + 32'(bubble_inc_c);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetch_q  <= '0;
         perf_bubble_q <= '0;
      end else begin
         perf_fetch_q  <= perf_fetch_d;
         perf_bubble_q <= perf_bubble_d;
      end
   end

   assign perf_fetch_cnt  = perf_fetch_q;
   assign perf_bubble_cnt = perf_bubble_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed vector table, a PC-wrap instance,
// and randomized traffic against a queue-based reference model.
module tb_if_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        ifid_valid;
   logic [31:0] ifid_instr;
   logic [31:0] ifid_pc4;
   logic [5:0]  opcode;

   logic        w_valid;
   logic [31:0] w_instr;
   logic [31:0] w_pc4;
   logic [5:0]  w_opcode;

`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt, perf_bubble_cnt;
   logic [31:0] w_perf_fetch, w_perf_bubble;
`endif

   int checks = 0;
   int errors = 0;

   if_stage_if #(.ADDR_W(32)) imem_bus ();
   if_stage_if #(.ADDR_W(32)) wbus ();

   if_stage #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem           (imem_bus),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .ifid_valid     (ifid_valid),
      .ifid_instr     (ifid_instr),
      .ifid_pc4       (ifid_pc4),
      .opcode         (opcode)
`ifdef IF_PERF_CNT_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_bubble_cnt(perf_bubble_cnt)
`endif
   );

   if_stage #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk            (clk),
      .rst            (rst),
      .imem           (wbus),
      .stall          (1'b0),
      .redirect_valid (1'b0),
      .redirect_pc    (32'h0),
      .ifid_valid     (w_valid),
      .ifid_instr     (w_instr),
      .ifid_pc4       (w_pc4),
      .opcode         (w_opcode)
`ifdef IF_PERF_CNT_EN
      ,
      .perf_fetch_cnt (w_perf_fetch),
      .perf_bubble_cnt(w_perf_bubble)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, stall, redir;
      logic [31:0] rpc;
      logic        ack;
      logic [31:0] rdata;
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic [5:0]  op;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic s, input logic d,
                               input logic [31:0] rp, input logic a,
                               input logic [31:0] rd, input logic q,
                               input logic [31:0] ad, input logic v,
                               input logic [31:0] ins, input logic [31:0] p4);
      vec_t t;
      t.rst = r; t.stall = s; t.redir = d; t.rpc = rp; t.ack = a; t.rdata = rd;
      t.req = q; t.addr = ad; t.valid = v; t.instr = ins; t.pc4 = p4;
      t.op = v ? ins[31:26] : 6'd0;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: "started" means out of the reset-exit cycle; a non-empty
   // skid queue means a word was accepted under stall and fetching is paused.
   logic [31:0] m_pc, m_instr, m_pc4, m_fetch, m_bubble;
   logic        m_valid, m_started;
   logic [63:0] m_skid[$];

   task automatic model_edge(input logic a, input logic [31:0] rd);
      logic [63:0] e;
      if (rst) begin
         m_pc = 32'h0; m_valid = 0; m_instr = 0; m_pc4 = 0; m_started = 0;
         m_skid.delete(); m_fetch = 0; m_bubble = 0;
      end else if (redirect_valid) begin
         m_pc = redirect_pc & 32'hFFFF_FFFC;
         m_valid = 0; m_skid.delete(); m_started = 1; m_bubble++;
      end else if (!m_started) begin
         m_started = 1;
      end else if (m_skid.size() != 0) begin
         if (!stall) begin
            e = m_skid.pop_front();
            m_valid = 1; m_instr = e[63:32]; m_pc4 = e[31:0]; m_fetch++;
         end
      end else if (a) begin
         if (stall) m_skid.push_back({rd, m_pc + 32'd4});
         else begin
            m_valid = 1; m_instr = rd; m_pc4 = m_pc + 32'd4; m_fetch++;
         end
         m_pc = m_pc + 32'd4;
      end else if (!stall) begin
         m_valid = 0; m_bubble++;
      end
   endtask

   vec_t vecs[22];

   initial begin
      logic a;
      logic [31:0] rd;
      logic [31:0] exp_op;

      rst = 1; stall = 0; redirect_valid = 0; redirect_pc = 0;
      imem_bus.imem_ack = 0; imem_bus.imem_rdata = 0;
      wbus.imem_ack = 0; wbus.imem_rdata = 0;

      //              rst s  d  rpc        ack rdata          req addr          v  instr          pc4
      vecs[0]  = mk(1, 0, 0, 32'h0,   0, 32'h0,         0, 32'h00, 0, 32'h0,         32'h00);
      vecs[1]  = mk(0, 0, 0, 32'h0,   1, 32'hDEAD_BEEF, 1, 32'h00, 0, 32'h0,         32'h00);
      vecs[2]  = mk(0, 0, 0, 32'h0,   1, 32'h1000_0000, 1, 32'h04, 1, 32'h1000_0000, 32'h04);
      vecs[3]  = mk(0, 0, 0, 32'h0,   1, 32'h1000_0004, 1, 32'h08, 1, 32'h1000_0004, 32'h08);
      vecs[4]  = mk(0, 0, 0, 32'h0,   1, 32'h1000_0008, 1, 32'h0C, 1, 32'h1000_0008, 32'h0C);
      vecs[5]  = mk(0, 0, 0, 32'h0,   1, 32'h1000_000C, 1, 32'h10, 1, 32'h1000_000C, 32'h10);
      vecs[6]  = mk(0, 0, 0, 32'h0,   0, 32'h0,         1, 32'h10, 0, 32'h1000_000C, 32'h10);
      vecs[7]  = mk(0, 0, 0, 32'h0,   0, 32'h0,         1, 32'h10, 0, 32'h1000_000C, 32'h10);
      vecs[8]  = mk(0, 0, 0, 32'h0,   0, 32'h0,         1, 32'h10, 0, 32'h1000_000C, 32'h10);
      vecs[9]  = mk(0, 0, 0, 32'h0,   1, 32'h2000_0010, 1, 32'h14, 1, 32'h2000_0010, 32'h14);
      vecs[10] = mk(0, 0, 0, 32'h0,   1, 32'h1000_0014, 1, 32'h18, 1, 32'h1000_0014, 32'h18);
      vecs[11] = mk(0, 0, 0, 32'h0,   1, 32'h1000_0018, 1, 32'h1C, 1, 32'h1000_0018, 32'h1C);
      vecs[12] = mk(0, 0, 0, 32'h0,   1, 32'h1000_001C, 1, 32'h20, 1, 32'h1000_001C, 32'h20);
      vecs[13] = mk(0, 1, 0, 32'h0,   1, 32'h8C00_0020, 0, 32'h24, 1, 32'h1000_001C, 32'h20);
      vecs[14] = mk(0, 1, 0, 32'h0,   0, 32'h0,         0, 32'h24, 1, 32'h1000_001C, 32'h20);
      vecs[15] = mk(0, 0, 0, 32'h0,   0, 32'h0,         1, 32'h24, 1, 32'h8C00_0020, 32'h24);
      vecs[16] = mk(0, 1, 1, 32'h103, 1, 32'hFC00_0000, 1, 32'h100, 0, 32'h8C00_0020, 32'h24);
      vecs[17] = mk(0, 0, 0, 32'h0,   0, 32'h0,         1, 32'h100, 0, 32'h8C00_0020, 32'h24);
      vecs[18] = mk(0, 0, 0, 32'h0,   1, 32'h0C00_0100, 1, 32'h104, 1, 32'h0C00_0100, 32'h104);
      vecs[19] = mk(0, 1, 0, 32'h0,   1, 32'h1111_1111, 0, 32'h108, 1, 32'h0C00_0100, 32'h104);
      vecs[20] = mk(1, 0, 0, 32'h0,   0, 32'h0,         0, 32'h00, 0, 32'h0,         32'h00);
      vecs[21] = mk(0, 0, 0, 32'h0,   1, 32'h5555_5555, 1, 32'h00, 0, 32'h0,         32'h00);

      for (int i = 0; i < 22; i++) begin
         rst = vecs[i].rst; stall = vecs[i].stall;
         redirect_valid = vecs[i].redir; redirect_pc = vecs[i].rpc;
         imem_bus.imem_ack = vecs[i].ack; imem_bus.imem_rdata = vecs[i].rdata;
         step();
         check($sformatf("vec%0d_req", i),   32'(imem_bus.imem_req), 32'(vecs[i].req));
         check($sformatf("vec%0d_addr", i),  imem_bus.imem_addr,     vecs[i].addr);
         check($sformatf("vec%0d_valid", i), 32'(ifid_valid),        32'(vecs[i].valid));
         check($sformatf("vec%0d_instr", i), ifid_instr,             vecs[i].instr);
         check($sformatf("vec%0d_pc4", i),   ifid_pc4,               vecs[i].pc4);
         check($sformatf("vec%0d_op", i),    32'(opcode),            32'(vecs[i].op));
`ifdef IF_PERF_CNT_EN
         if (i == 20) begin
            check("rst_perf_fetch",  perf_fetch_cnt,  32'h0);
            check("rst_perf_bubble", perf_bubble_cnt, 32'h0);
         end
`endif
      end

      // PC wrap: the second instance resets to 0xFFFF_FFFC and is now fetching there
      imem_bus.imem_ack = 0;
      check("wrap_addr_pre", wbus.imem_addr, 32'hFFFF_FFFC);
      check("wrap_req_pre",  32'(wbus.imem_req), 32'h1);
      wbus.imem_ack = 1; wbus.imem_rdata = 32'h1234_5678;
      step();
      wbus.imem_ack = 0;
      check("wrap_pc4",   w_pc4,   32'h0);
      check("wrap_addr",  wbus.imem_addr, 32'h0);
      check("wrap_valid", 32'(w_valid), 32'h1);
      check("wrap_op",    32'(w_opcode), 32'h04);

      // Randomized traffic against the reference model
      rst = 1; stall = 0; redirect_valid = 0; imem_bus.imem_ack = 0;
      model_edge(1'b0, 32'h0);
      step();
      rst = 0;
      for (int c = 0; c < 3000; c++) begin
         rst            = ($urandom_range(0, 199) == 0);
         stall          = ($urandom_range(0, 2) == 0);
         redirect_valid = ($urandom_range(0, 15) == 0);
         redirect_pc    = $urandom();
         a              = ($urandom_range(0, 1) == 1);
         rd             = $urandom();
         imem_bus.imem_ack   = a;
         imem_bus.imem_rdata = rd;
         model_edge(a, rd);
         step();
         exp_op = m_valid ? 32'(m_instr[31:26]) : 32'h0;
         check("rnd_req",   32'(imem_bus.imem_req), 32'(m_started && m_skid.size() == 0));
         check("rnd_addr",  imem_bus.imem_addr, m_pc);
         check("rnd_valid", 32'(ifid_valid), 32'(m_valid));
         check("rnd_instr", ifid_instr, m_instr);
         check("rnd_pc4",   ifid_pc4, m_pc4);
         check("rnd_op",    32'(opcode), exp_op);
`ifdef IF_PERF_CNT_EN
         check("rnd_perf_fetch",  perf_fetch_cnt,  m_fetch);
         check("rnd_perf_bubble", perf_bubble_cnt, m_bubble);
`endif
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
